// File: rtl/prog_seq.sv
// prog_seq: program sequencer driving PC control (Start, Jen, Jump, StallCtr) with jump LUT and Req/Done handshake
//   Clk, Reset         clock, synchronous active-high reset
//   Req                host run request (IDLE/HALT only)
//   Instr, PC, Zero    fetched instruction, current PC, ALU zero flag (qualified inside the PC)
//   LutWe/Addr/Data    jump-LUT write port, honoured in IDLE only
//   Start, Jen, Jump   PC hold, jump enable, jump target
//   StallCtr           multi-cycle stall indicator
//   Done, HaltPC       completion flag and PC captured at HALT
module prog_seq #(
  parameter int PC_W      = 8,
  parameter int LUT_DEPTH = 8,
  parameter int STALL_CYC = 4
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Req,
  input  logic [8:0]      Instr,
  input  logic [PC_W-1:0] PC,
  input  logic            Zero,
  input  logic            LutWe,
  input  logic [2:0]      LutAddr,
  input  logic [PC_W-1:0] LutData,
  output logic            Start,
  output logic            Jen,
  output logic [PC_W-1:0] Jump,
  output logic            StallCtr,
  output logic            Done,
  output logic [PC_W-1:0] HaltPC
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] STALL = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;
  logic [1:0]      state, nxt;
  logic [2:0]      cnt;
  logic [2:0]      op;
  logic [PC_W-1:0] lut [LUT_DEPTH];
  logic            unused_bits;
  assign op          = Instr[8:6];
  // Zero is qualified by the PC itself; Instr[5:3] carries no sequencer information
  assign unused_bits = ^{Zero, Instr[5:3]};
  always_comb begin
    nxt = state == IDLE  ? (Req ? RUN : IDLE) :
          state == RUN   ? (op == 3'b110 ? STALL : op == 3'b101 ? HALT : RUN) :
          state == STALL ? (cnt == 3'd0 ? RUN : STALL) :
                           (Req ? HALT : IDLE);
  end
  assign Start    = state == IDLE || state == HALT;
  assign StallCtr = state == STALL;
  assign Jen      = state == RUN && op == 3'b111;
  assign Jump     = Jen ? lut[Instr[2:0]] : '0;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      Done   <= 1'b0;
      HaltPC <= '0;
      lut    <= '{default: '0};
    end else begin
      state  <= nxt;
      // count is reloaded on entry and only decremented while in STALL, so its wrap at exit is harmless
      cnt    <= state == RUN && op == 3'b110 ? 3'(STALL_CYC - 1) : state == STALL ? cnt - 3'd1 : cnt;
      Done   <= state == HALT && Req;
      HaltPC <= state == RUN && op == 3'b101 ? PC : HaltPC;
      if (state == IDLE && LutWe) lut[LutAddr] <= LutData;
    end
  end
endmodule
